// File: rtl/dunc16_pkg.sv
// rtl/dunc16_pkg.sv - shared types and constants for the dunc16 memory/IO controller
package dunc16_pkg;

    localparam int DUNC16_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_IO,
        RGN_OOR
    } region_t;

    localparam logic [3:0] IO_OFS_OUT = 4'd0;
    localparam logic [3:0] IO_OFS_IN  = 4'd1;
    localparam logic [3:0] IO_OFS_CNT = 4'd2;

endpackage

// File: rtl/dunc16_io_regs.sv
// rtl/dunc16_io_regs.sv - IO window: output latch, strobe, transaction counter, read mux
module dunc16_io_regs
    import dunc16_pkg::*;
#(
    parameter int DATA_W = DUNC16_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              done,
    input  logic              io_sel,
    input  logic              we,
    input  logic [3:0]        ofs,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_stb,
    output logic [DATA_W-1:0] io_rdata
);

    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              out_wr;

    assign out_wr = io_sel && we && (ofs == IO_OFS_OUT);

    // Next-state for the latch (on an offset-0 write) and the completion counter (every DONE)
    always_comb begin
        io_out_d = io_out_q;
        cnt_d    = cnt_q;
        if (out_wr) begin
            io_out_d = wdata;
        end
        if (done) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            io_out_q <= '0;
            cnt_q    <= '0;
        end else begin
            io_out_q <= io_out_d;
            cnt_q    <= cnt_d;
        end
    end

    // Read mux; the counter value seen is the one before this transaction is counted
    always_comb begin
        io_rdata = '0;
        case (ofs)
            IO_OFS_OUT: io_rdata = io_out_q;
            IO_OFS_IN:  io_rdata = io_in;
            IO_OFS_CNT: io_rdata = DATA_W'(cnt_q);
            default:    io_rdata = '0;
        endcase
    end

    assign io_out = io_out_q;
    assign io_stb = out_wr;

endmodule

// File: rtl/dunc16_mem_ctrl.sv
// rtl/dunc16_mem_ctrl.sv - REQ/READY to synchronous RAM strobes with wait states and IO window
module dunc16_mem_ctrl
    import dunc16_pkg::*;
#(
    parameter int          DATA_W      = DUNC16_DATA_W,
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFFF0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [15:0]       ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              READY,
    output logic              ERR,
    output logic              BUSY,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic [DATA_W-1:0] IO_IN,
    output logic [DATA_W-1:0] IO_OUT,
    output logic              IO_STB
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state_q, state_d;
    region_t           region_q, region_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        io_ofs_q, io_ofs_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] io_rdata;
    logic              ram_hit, io_hit;

    assign ram_hit = ((ADDR >> ADDR_W) == 16'd0);
    assign io_hit  = (ADDR[15:4] == IO_BASE[15:4]);

    // Next-state, request latching, read-data capture and strobe decode
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        mem_addr_d = mem_addr_q;
        io_ofs_d   = io_ofs_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    mem_addr_d = ADDR[ADDR_W-1:0];
                    io_ofs_d   = ADDR[3:0];
                    we_d       = WE;
                    wdata_d    = WDATA;
                    if (ram_hit) begin
                        region_d = RGN_RAM;
                        state_d  = ST_ACCESS;
                    end else if (io_hit) begin
                        region_d = RGN_IO;
                        state_d  = ST_DONE;
                    end else begin
                        region_d = RGN_OOR;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (WS != 4'd0) begin
                    wait_cnt_d = WS;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!we_q) begin
                    case (region_q)
                        RGN_RAM: rdata_d = MEM_RDATA;
                        RGN_IO:  rdata_d = io_rdata;
                        default: rdata_d = '0;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            region_q   <= RGN_RAM;
            mem_addr_q <= '0;
            io_ofs_q   <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            mem_addr_q <= mem_addr_d;
            io_ofs_q   <= io_ofs_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign MEM_EN    = (state_q == ST_ACCESS);
    assign MEM_WE    = (state_q == ST_ACCESS) && we_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = wdata_q;
    assign READY     = (state_q == ST_DONE);
    assign ERR       = (state_q == ST_DONE) && (region_q == RGN_OOR);
    assign RDATA     = rdata_q;

    dunc16_io_regs #(
        .DATA_W (DATA_W)
    ) u_io_regs (
        .CLK      (CLK),
        .RESET    (RESET),
        .done     (state_q == ST_DONE),
        .io_sel   ((state_q == ST_DONE) && (region_q == RGN_IO)),
        .we       (we_q),
        .ofs      (io_ofs_q),
        .wdata    (wdata_q),
        .io_in    (IO_IN),
        .io_out   (IO_OUT),
        .io_stb   (IO_STB),
        .io_rdata (io_rdata)
    );

endmodule
